// File: rtl/mux_rr_arbiter_if.sv
// Requester/downstream bundle for mux_rr_arbiter.
// MUX_ARB_BURST_EN adds the per-requester req_last_in burst delimiter.
interface mux_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int SEL_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid_in;
  logic [NUM_REQ*DATA_W-1:0] req_data_in;
  logic [NUM_REQ-1:0]        req_ready_out;
`ifdef MUX_ARB_BURST_EN
  logic [NUM_REQ-1:0]        req_last_in;
`endif
  logic [DATA_W-1:0]         y_data_out;
  logic                      y_valid_out;
  logic                      y_ready_in;
  logic [NUM_REQ-1:0]        grant_out;
  logic [SEL_W-1:0]          sel_out;
  logic                      busy_out;

  modport slave (
    input  req_valid_in, req_data_in, y_ready_in,
`ifdef MUX_ARB_BURST_EN
    input  req_last_in,
`endif
    output req_ready_out, y_data_out, y_valid_out, grant_out, sel_out, busy_out
  );

  modport master (
    output req_valid_in, req_data_in, y_ready_in,
`ifdef MUX_ARB_BURST_EN
    output req_last_in,
`endif
    input  req_ready_out, y_data_out, y_valid_out, grant_out, sel_out, busy_out
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select of an N:1 data mux with valid/ready on both sides.
// MUX_ARB_BURST_EN: grants are held until a transfer carrying req_last_in.
module mux_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input logic             clk_in,
  input logic             rst_n_in,
  mux_rr_arbiter_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   winner, winner_inc;
  logic               any_valid;
  logic               last_beat;
  logic               xfer;

  // Rotating search from ptr; since ptr sits just past the holder, the holder ranks last.
  always_comb begin
    logic [SEL_W:0]   sum;
    logic [SEL_W-1:0] idx;
    any_valid = 1'b0;
    winner    = '0;
    sum       = '0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_q} + (SEL_W+1)'(i);
      if (sum >= (SEL_W+1)'(NUM_REQ)) sum = sum - (SEL_W+1)'(NUM_REQ);
      idx = sum[SEL_W-1:0];
      if (!any_valid && bus.req_valid_in[idx]) begin
        any_valid = 1'b1;
        winner    = idx;
      end
    end
    winner_inc = (winner == SEL_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
  end

`ifdef MUX_ARB_BURST_EN
  assign last_beat = bus.req_last_in[sel_q];
`else
  assign last_beat = 1'b1;
`endif

  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    sel_d             = sel_q;
    ptr_d             = ptr_q;
    xfer              = 1'b0;
    bus.y_valid_out   = 1'b0;
    bus.y_data_out    = '0;
    bus.req_ready_out = '0;
    bus.busy_out      = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d = GRANT;
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
          sel_d   = winner;
          ptr_d   = winner_inc;
        end
      end
      GRANT: begin
        bus.busy_out             = 1'b1;
        bus.y_valid_out          = bus.req_valid_in[sel_q];
        bus.y_data_out           = bus.req_data_in[sel_q*DATA_W +: DATA_W];
        bus.req_ready_out[sel_q] = bus.y_ready_in;
        xfer = bus.req_valid_in[sel_q] & bus.y_ready_in;
        if (xfer && last_beat) begin
          if (any_valid) begin
            grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
            sel_d   = winner;
            ptr_d   = winner_inc;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (!xfer && !bus.req_valid_in[sel_q]) begin
          // Holder withdrew valid without a handshake: drop the grant, keep ptr.
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.grant_out = grant_q;
  assign bus.sel_out   = sel_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter; burst steps run only when MUX_ARB_BURST_EN is defined.
module tb_mux_rr_arbiter;
  logic clk;
  logic rst_n;
  int unsigned n_vec;
  int unsigned n_err;

  mux_rr_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

  mux_rr_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.req_valid_in = '0;
    bus.req_data_in  = '0;
    bus.y_ready_in   = 1'b0;
`ifdef MUX_ARB_BURST_EN
    bus.req_last_in  = '1;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", bus.grant_out, 4'b0000);
    chk("rst_sel", bus.sel_out, 2'd0);
    chk("rst_busy", bus.busy_out, 1'b0);
    chk("rst_yvalid", bus.y_valid_out, 1'b0);
    chk("rst_ready", bus.req_ready_out, 4'b0000);
    rst_n = 1'b1;

    // Reset while req1 holds the grant
    bus.req_valid_in = 4'b0010;
    bus.req_data_in  = {8'h13, 8'h12, 8'h11, 8'h10};
    step();
    chk("t1_grant", bus.grant_out, 4'b0010);
    chk("t1_busy", bus.busy_out, 1'b1);
    bus.y_ready_in = 1'b1;
    #1;
    chk("t1_ready_pre", bus.req_ready_out, 4'b0010);
    rst_n = 1'b0;
    #1;
    chk("t1_yvalid_rst", bus.y_valid_out, 1'b0);
    chk("t1_ready_rst", bus.req_ready_out, 4'b0000);
    chk("t1_busy_rst", bus.busy_out, 1'b0);
    chk("t1_grant_rst", bus.grant_out, 4'b0000);
    chk("t1_sel_rst", bus.sel_out, 2'd0);

    // All four valid, ready high: 0,1,2,3,0 with no bubble
    bus.req_valid_in = 4'b1111;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_grant", bus.grant_out, 32'd1 << (k % 4));
      chk("t3_sel", bus.sel_out, 32'(k % 4));
      chk("t3_data", bus.y_data_out, 32'h10 + 32'(k % 4));
      chk("t3_ready", bus.req_ready_out, 32'd1 << (k % 4));
      chk("t3_yvalid", bus.y_valid_out, 1'b1);
    end
    bus.req_valid_in = 4'b0000;
    step();
    chk("t3_idle_busy", bus.busy_out, 1'b0);
    chk("t3_idle_grant", bus.grant_out, 4'b0000);

    // Single request from req2
    bus.req_valid_in = 4'b0100;
    bus.req_data_in  = {8'h13, 8'hA5, 8'h11, 8'h10};
    step();
    chk("t2_grant", bus.grant_out, 4'b0100);
    chk("t2_sel", bus.sel_out, 2'd2);
    chk("t2_data", bus.y_data_out, 8'hA5);
    chk("t2_yvalid", bus.y_valid_out, 1'b1);
    chk("t2_ready", bus.req_ready_out, 4'b0100);
    step();
    bus.req_valid_in = 4'b0000;
    step();
    chk("t2_idle_busy", bus.busy_out, 1'b0);
    chk("t2_idle_grant", bus.grant_out, 4'b0000);
    chk("t2_idle_data", bus.y_data_out, 8'h00);

    // Backpressure on req1 for three cycles
    bus.req_valid_in = 4'b0010;
    bus.req_data_in  = {8'h13, 8'h12, 8'h3C, 8'h10};
    bus.y_ready_in   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t4_grant", bus.grant_out, 4'b0010);
      chk("t4_sel", bus.sel_out, 2'd1);
      chk("t4_data", bus.y_data_out, 8'h3C);
      chk("t4_ready", bus.req_ready_out, 4'b0000);
    end
    bus.y_ready_in   = 1'b1;
    bus.req_valid_in = 4'b1010;
    #1;
    chk("t4_ready_go", bus.req_ready_out, 4'b0010);
    chk("t4_yvalid_go", bus.y_valid_out, 1'b1);
    step();
    chk("t4_next_grant", bus.grant_out, 4'b1000);

    // req3 withdraws valid before any transfer
    bus.y_ready_in   = 1'b0;
    bus.req_valid_in = 4'b0000;
    #1;
    chk("t5_yvalid", bus.y_valid_out, 1'b0);
    step();
    chk("t5_busy", bus.busy_out, 1'b0);
    chk("t5_grant", bus.grant_out, 4'b0000);
    bus.req_valid_in = 4'b1111;
    step();
    chk("t5_ptr_grant", bus.grant_out, 4'b0001);
    bus.req_valid_in = 4'b0000;
    step();
    chk("t5_end_busy", bus.busy_out, 1'b0);

`ifdef MUX_ARB_BURST_EN
    // req0 sends three beats while req1 waits
    bus.req_last_in  = 4'b0000;
    bus.req_valid_in = 4'b0001;
    step();
    chk("t6_grant0", bus.grant_out, 4'b0001);
    bus.req_valid_in = 4'b0011;
    bus.y_ready_in   = 1'b1;
    step();
    chk("t6_beat1_hold", bus.grant_out, 4'b0001);
    step();
    chk("t6_beat2_hold", bus.grant_out, 4'b0001);
    bus.req_last_in = 4'b0001;
    #1;
    chk("t6_beat3_ready", bus.req_ready_out, 4'b0001);
    step();
    chk("t6_grant1", bus.grant_out, 4'b0010);
    bus.req_valid_in = 4'b0000;
    bus.req_last_in  = 4'b1111;
    step();
    chk("t6_end_busy", bus.busy_out, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
